// File: rtl/cond_unit_banked.sv
// Conditional-execution unit with NCTX banked NZCV flag registers.
// Gates per-instruction control writes by the ARM condition and registers the result in one output slot.
module cond_unit_banked #(
    parameter int NCTX  = 2,
    parameter int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTX_W-1:0]     in_ctx,
    input  logic [3:0]           in_cond,
    input  logic [3:0]           in_alu_flags,
    input  logic [1:0]           in_flag_w,
    input  logic                 in_pcs,
    input  logic                 in_regw,
    input  logic                 in_memw,
    input  logic                 restore_en,
    input  logic [CTX_W-1:0]     restore_ctx,
    input  logic [3:0]           restore_flags,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_pcsrc,
    output logic                 out_regwrite,
    output logic                 out_memwrite,
    output logic                 out_condex,
    output logic                 out_undef,
    output logic [4*NCTX-1:0]    flags_out,
    output logic [CNT_W-1:0]     squash_cnt,
    input  logic                 cnt_clr
);

    // Returns {condex, undef} for a condition code against {N,Z,C,V}.
    function automatic logic [1:0] cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, ge, pass;
        n    = nzcv[3];
        z    = nzcv[2];
        c    = nzcv[1];
        v    = nzcv[0];
        ge   = (n == v);
        pass = 1'b0;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~(c & ~z);
            4'b1010: pass = ge;
            4'b1011: pass = ~ge;
            4'b1100: pass = ~z & ge;
            4'b1101: pass = ~(~z & ge);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return {pass, (cond == 4'b1111)};
    endfunction

    logic [NCTX-1:0][3:0] flags_q, flags_d;
    logic                 valid_q, valid_d;
    logic                 pcsrc_q, pcsrc_d;
    logic                 regw_q, regw_d;
    logic                 memw_q, memw_d;
    logic                 condex_q, condex_d;
    logic                 undef_q, undef_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           cur_flags;
    logic                 condex, undef, accept;

    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        flags_d   = flags_q;
        valid_d   = valid_q;
        pcsrc_d   = pcsrc_q;
        regw_d    = regw_q;
        memw_d    = memw_q;
        condex_d  = condex_q;
        undef_d   = undef_q;
        cnt_d     = cnt_q;
        cur_flags = flags_q[in_ctx];
        {condex, undef} = cond_eval(in_cond, cur_flags);

        if (accept) begin
            valid_d  = 1'b1;
            condex_d = condex;
            undef_d  = undef;
            pcsrc_d  = in_pcs & condex;
            regw_d   = in_regw & condex;
            memw_d   = in_memw & condex;
            if (condex) begin
                if (in_flag_w[1]) flags_d[in_ctx][3:2] = in_alu_flags[3:2];
                if (in_flag_w[0]) flags_d[in_ctx][1:0] = in_alu_flags[1:0];
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // Restore is applied last so it overrides an instruction write to the same bank.
        if (restore_en) flags_d[restore_ctx] = restore_flags;
        if (cnt_clr) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= '0;
            valid_q  <= 1'b0;
            pcsrc_q  <= 1'b0;
            regw_q   <= 1'b0;
            memw_q   <= 1'b0;
            condex_q <= 1'b0;
            undef_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            pcsrc_q  <= pcsrc_d;
            regw_q   <= regw_d;
            memw_q   <= memw_d;
            condex_q <= condex_d;
            undef_q  <= undef_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pcsrc    = pcsrc_q;
    assign out_regwrite = regw_q;
    assign out_memwrite = memw_q;
    assign out_condex   = condex_q;
    assign out_undef    = undef_q;
    assign flags_out    = flags_q;
    assign squash_cnt   = cnt_q;

endmodule

// File: tb/tb_cond_unit_banked.sv
// Bench for cond_unit_banked: two instances (16-bit and 2-bit squash counters) share stimulus
// and are compared every cycle against a behavioural flag/condition model.
module tb_cond_unit_banked;
    localparam int NCTX  = 2;
    localparam int CTX_W = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1;
    logic [CTX_W-1:0] in_ctx = '0, restore_ctx = '0;
    logic [3:0] in_cond = 4'hE, in_alu_flags = 4'h0, restore_flags = 4'h0;
    logic [1:0] in_flag_w = 2'b00;
    logic in_pcs = 1'b0, in_regw = 1'b0, in_memw = 1'b0;
    logic restore_en = 1'b0, cnt_clr = 1'b0;

    logic in_ready, out_valid, out_pcsrc, out_regwrite, out_memwrite, out_condex, out_undef;
    logic [4*NCTX-1:0] flags_out;
    logic [15:0] squash_cnt;
    logic in_ready_n, out_valid_n, out_pcsrc_n, out_regwrite_n, out_memwrite_n, out_condex_n, out_undef_n;
    logic [4*NCTX-1:0] flags_out_n;
    logic [1:0] squash_cnt_n;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [3:0] mbank [NCTX];
    logic m_valid, m_pcs, m_regw, m_memw, m_condex, m_undef;
    int m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    cond_unit_banked #(.NCTX(NCTX), .CTX_W(CTX_W), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctx(in_ctx), .in_cond(in_cond), .in_alu_flags(in_alu_flags), .in_flag_w(in_flag_w),
        .in_pcs(in_pcs), .in_regw(in_regw), .in_memw(in_memw),
        .restore_en(restore_en), .restore_ctx(restore_ctx), .restore_flags(restore_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_pcsrc(out_pcsrc),
        .out_regwrite(out_regwrite), .out_memwrite(out_memwrite), .out_condex(out_condex),
        .out_undef(out_undef), .flags_out(flags_out), .squash_cnt(squash_cnt), .cnt_clr(cnt_clr)
    );

    cond_unit_banked #(.NCTX(NCTX), .CTX_W(CTX_W), .CNT_W(2)) dut_n (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_ctx(in_ctx), .in_cond(in_cond), .in_alu_flags(in_alu_flags), .in_flag_w(in_flag_w),
        .in_pcs(in_pcs), .in_regw(in_regw), .in_memw(in_memw),
        .restore_en(restore_en), .restore_ctx(restore_ctx), .restore_flags(restore_flags),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_pcsrc(out_pcsrc_n),
        .out_regwrite(out_regwrite_n), .out_memwrite(out_memwrite_n), .out_condex(out_condex_n),
        .out_undef(out_undef_n), .flags_out(flags_out_n), .squash_cnt(squash_cnt_n), .cnt_clr(cnt_clr)
    );

    // Condition pass: even codes test a base predicate, odd codes test its inverse.
    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        case (c / 2)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return (c % 2 == 1) ? !base : base;
    endfunction

    function automatic logic [4*NCTX-1:0] model_flags();
        logic [4*NCTX-1:0] r;
        for (int k = 0; k < NCTX; k++) r[4*k +: 4] = mbank[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCTX; k++) mbank[k] = 4'h0;
        m_valid = 0; m_pcs = 0; m_regw = 0; m_memw = 0; m_condex = 0; m_undef = 0;
        m_cnt16 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step();
        logic rdy, acc, ce;
        logic [3:0] f;
        rdy = !m_valid || out_ready;
        acc = in_valid && rdy;
        f   = mbank[in_ctx];
        ce  = passes(in_cond, f);
        if (acc) begin
            m_valid  = 1;
            m_condex = ce;
            m_undef  = (in_cond == 4'd15);
            m_pcs    = in_pcs && ce;
            m_regw   = in_regw && ce;
            m_memw   = in_memw && ce;
            if (ce) begin
                if (in_flag_w[1]) f[3:2] = in_alu_flags[3:2];
                if (in_flag_w[0]) f[1:0] = in_alu_flags[1:0];
                mbank[in_ctx] = f;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (restore_en) mbank[restore_ctx] = restore_flags;
        if (cnt_clr) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (acc && !ce) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".valid_n"}, {31'd0, out_valid_n}, {31'd0, m_valid});
        if (m_valid) begin
            chk({tag, ".ctl"}, {27'd0, out_condex, out_undef, out_pcsrc, out_regwrite, out_memwrite},
                {27'd0, m_condex, m_undef, m_pcs, m_regw, m_memw});
            chk({tag, ".ctl_n"}, {27'd0, out_condex_n, out_undef_n, out_pcsrc_n, out_regwrite_n, out_memwrite_n},
                {27'd0, m_condex, m_undef, m_pcs, m_regw, m_memw});
        end
        chk({tag, ".flags"}, {24'd0, flags_out}, {24'd0, model_flags()});
        chk({tag, ".flags_n"}, {24'd0, flags_out_n}, {24'd0, model_flags()});
        chk({tag, ".cnt16"}, {16'd0, squash_cnt}, m_cnt16);
        chk({tag, ".cnt2"}, {30'd0, squash_cnt_n}, m_cnt2);
    endtask

    // One clock: check combinational ready, advance model at the edge, check registered outputs.
    task automatic step(input string tag);
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        chk({tag, ".in_ready_n"}, {31'd0, in_ready_n}, {31'd0, (!m_valid || out_ready)});
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic issue(input logic [CTX_W-1:0] ctx, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] alu, input logic pcs, input logic regw, input logic memw);
        in_valid = 1; in_ctx = ctx; in_cond = cond; in_flag_w = fw; in_alu_flags = alu;
        in_pcs = pcs; in_regw = regw; in_memw = memw;
    endtask

    task automatic idle();
        in_valid = 0; in_flag_w = 2'b00; in_pcs = 0; in_regw = 0; in_memw = 0;
        restore_en = 0; cnt_clr = 0;
    endtask

    initial begin
        model_reset();
        #12 reset_n = 1;
        #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.outs", {26'd0, out_valid, out_condex, out_undef, out_pcsrc, out_regwrite, out_memwrite}, 32'd0);
        check_all("reset");

        issue(0, 4'hE, 2'b11, 4'b0100, 0, 1, 0);
        step("al_write");
        chk("al_write.regw", {31'd0, out_regwrite}, 32'd1);
        chk("al_write.bank0", {28'd0, flags_out[3:0]}, 32'h4);
        issue(0, 4'h0, 2'b00, 4'h0, 0, 1, 0);
        step("eq_pass");
        chk("eq_pass.condex", {31'd0, out_condex}, 32'd1);

        issue(1, 4'h0, 2'b00, 4'h0, 0, 1, 1);
        step("eq_fail");
        chk("eq_fail.wr", {30'd0, out_regwrite, out_memwrite}, 32'd0);
        chk("eq_fail.cnt", {16'd0, squash_cnt}, 32'd1);
        issue(1, 4'h0, 2'b11, 4'hF, 0, 0, 0);
        step("fail_nowrite");
        chk("fail_nowrite.bank1", {28'd0, flags_out[7:4]}, 32'h0);

        out_ready = 0;
        issue(0, 4'hE, 2'b11, 4'hF, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            in_valid = ~in_valid;
        end
        in_valid = 1;
        out_ready = 1;
        step("release");
        chk("release.bank0", {28'd0, flags_out[3:0]}, 32'hF);

        issue(0, 4'hF, 2'b00, 4'h0, 1, 0, 0);
        step("undef");
        chk("undef.bits", {30'd0, out_undef, out_pcsrc}, 32'b10);

        idle();
        restore_en = 1; restore_ctx = 0; restore_flags = 4'b1001;
        step("restore_1001");
        restore_en = 0;
        issue(0, 4'hC, 2'b00, 4'h0, 0, 1, 0);
        step("gt");
        chk("gt.condex", {31'd0, out_condex}, 32'd1);
        idle();
        restore_en = 1; restore_ctx = 0; restore_flags = 4'b1000;
        step("restore_1000");
        restore_en = 0;
        issue(0, 4'hB, 2'b00, 4'h0, 0, 1, 0);
        step("lt");
        chk("lt.condex", {31'd0, out_condex}, 32'd1);

        issue(0, 4'hE, 2'b11, 4'b1100, 0, 0, 0);
        restore_en = 1; restore_ctx = 0; restore_flags = 4'b0010;
        step("restore_wins");
        chk("restore_wins.bank0", {28'd0, flags_out[3:0]}, 32'h2);
        restore_ctx = 1; restore_flags = 4'b0100;
        issue(1, 4'h0, 2'b11, 4'hF, 0, 1, 0);
        step("pre_restore_eval");
        chk("pre_restore_eval.condex", {31'd0, out_condex}, 32'd0);
        idle();

        cnt_clr = 1;
        step("clr");
        cnt_clr = 0;
        for (int i = 0; i < 5; i++) begin
            issue(i % 2, 4'hF, 2'b00, 4'h0, 0, 0, 0);
            step("sat");
        end
        chk("sat.cnt2", {30'd0, squash_cnt_n}, 32'd3);
        cnt_clr = 1;
        step("clr_wins");
        chk("clr_wins.cnt2", {30'd0, squash_cnt_n}, 32'd0);
        idle();

        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            in_ctx        = CTX_W'($urandom_range(0, NCTX - 1));
            in_cond       = 4'($urandom);
            in_alu_flags  = 4'($urandom);
            in_flag_w     = 2'($urandom);
            in_pcs        = 1'($urandom);
            in_regw       = 1'($urandom);
            in_memw       = 1'($urandom);
            restore_en    = ($urandom_range(0, 7) == 0);
            restore_ctx   = CTX_W'($urandom_range(0, NCTX - 1));
            restore_flags = 4'($urandom);
            cnt_clr       = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        idle();
        out_ready = 1;
        issue(1, 4'hE, 2'b11, 4'h6, 0, 1, 0);
        step("pre_reset");
        in_valid = 0;
        reset_n = 0;
        #1;
        model_reset();
        chk("midreset.valid", {31'd0, out_valid}, 32'd0);
        chk("midreset.flags", {24'd0, flags_out}, 32'd0);
        check_all("midreset");
        #2 reset_n = 1;
        step("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
